// File: rtl/eco_chk_pkg.sv
// Shared types and defaults for the ECO response checker and its golden model.
package eco_chk_pkg;

   localparam int unsigned DEF_WIDTH      = 3;
   localparam int unsigned DEF_SETTLE_CYC = 1;
   localparam logic [DEF_WIDTH-1:0] DEF_PATCH_MASK = 3'b010;
   localparam int unsigned GOLD_MAX_W     = 16;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      DONE
   } state_e;

   // Bitwise NOR with ECO-patched positions tied low; callers narrow to their width.
   function automatic logic [GOLD_MAX_W-1:0] gold_y(
      input logic [GOLD_MAX_W-1:0] a,
      input logic [GOLD_MAX_W-1:0] b,
      input logic [GOLD_MAX_W-1:0] mask
   );
      return ~(a | b) & ~mask;
   endfunction

endpackage

// File: rtl/eco_gold_model.sv
// Combinational expected-response generator for the bitwise-NOR ECO netlists.
module eco_gold_model
   import eco_chk_pkg::*;
#(
   parameter int unsigned      WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] PATCH_MASK = DEF_PATCH_MASK
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_exp_c
);

   assign o_exp_c = WIDTH'(gold_y(GOLD_MAX_W'(i_a), GOLD_MAX_W'(i_b), GOLD_MAX_W'(PATCH_MASK)));

endmodule

// File: rtl/eco_resp_checker.sv
// Sweeps every (a,b) vector into an ECO netlist and checks y against the golden model.
// Optional macro ECO_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module eco_resp_checker
   import eco_chk_pkg::*;
#(
   parameter int unsigned      WIDTH      = DEF_WIDTH,
   parameter int unsigned      SETTLE_CYC = DEF_SETTLE_CYC,
   parameter logic [WIDTH-1:0] PATCH_MASK = DEF_PATCH_MASK
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   input  logic [WIDTH-1:0]     dut_y,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic                 fail_valid,
   output logic [2*WIDTH-1:0]   fail_vec,
   output logic [WIDTH-1:0]     fail_y
);

   localparam int unsigned VW = 2 * WIDTH;
   localparam int unsigned EW = 2 * WIDTH + 1;
   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   state_e          r_state;
   logic [VW-1:0]   r_v;
   logic [SW-1:0]   r_settle;

   logic [WIDTH-1:0] w_exp;
   logic             w_mismatch;
   logic             w_last;
   logic             w_stop;

   eco_gold_model #(
      .WIDTH      (WIDTH),
      .PATCH_MASK (PATCH_MASK)
   ) u_gold (
      .i_a     (r_v[VW-1:WIDTH]),
      .i_b     (r_v[WIDTH-1:0]),
      .o_exp_c (w_exp)
   );

   // Case-inequality so an X/Z response is reported as a mismatch.
   assign w_mismatch = (dut_y !== w_exp);
   assign w_last     = (r_v == {VW{1'b1}});

`ifdef ECO_CHK_STOP_ON_FAIL_EN
   assign w_stop = w_last | w_mismatch;
`else
   assign w_stop = w_last;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_v        <= '0;
         r_settle   <= '0;
         dut_a      <= '0;
         dut_b      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
         fail_y     <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state    <= DRIVE;
                  r_v        <= '0;
                  r_settle   <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
                  fail_y     <= '0;
               end
            end

            DRIVE: begin
               dut_a   <= r_v[VW-1:WIDTH];
               dut_b   <= r_v[WIDTH-1:0];
               r_state <= (SETTLE_CYC > 0) ? SETTLE : CHECK;
            end

            SETTLE: begin
               if (r_settle == SETTLE_LAST) begin
                  r_settle <= '0;
                  r_state  <= CHECK;
               end else begin
                  r_settle <= r_settle + SW'(1);
               end
            end

            CHECK: begin
               if (w_mismatch) begin
                  err_count <= err_count + EW'(1);
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= r_v;
                     fail_y     <= dut_y;
                  end
               end
               // pass folds in this cycle's result since err_count updates in parallel.
               if (w_stop) begin
                  r_state <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= (err_count == '0) && !w_mismatch;
               end else begin
                  r_v     <= r_v + VW'(1);
                  r_state <= DRIVE;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eco_resp_checker.sv
// Scoreboard bench for eco_resp_checker: default settle instance plus a zero-settle instance.
module tb_eco_resp_checker;

   typedef struct {
      int         err;
      logic       pass;
      logic       fv;
      logic [5:0] vec;
      logic [2:0] y;
      int         lat;
   } exp_t;

   logic clk;
   logic rst;
   logic start, start_z;
   int   mode;

   logic [2:0] dut_a, dut_b, dut_y;
   logic       busy, done, pass, fail_valid;
   logic [6:0] err_count;
   logic [5:0] fail_vec;
   logic [2:0] fail_y;

   logic [2:0] dut_a_z, dut_b_z, dut_y_z;
   logic       busy_z, done_z, pass_z, fail_valid_z;
   logic [6:0] err_count_z;
   logic [5:0] fail_vec_z;
   logic [2:0] fail_y_z;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   eco_resp_checker u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dut_a      (dut_a),
      .dut_b      (dut_b),
      .dut_y      (dut_y),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_valid (fail_valid),
      .fail_vec   (fail_vec),
      .fail_y     (fail_y)
   );

   eco_resp_checker #(.SETTLE_CYC(0)) u_dut_z (
      .clk        (clk),
      .rst        (rst),
      .start      (start_z),
      .dut_a      (dut_a_z),
      .dut_b      (dut_b_z),
      .dut_y      (dut_y_z),
      .busy       (busy_z),
      .done       (done_z),
      .pass       (pass_z),
      .err_count  (err_count_z),
      .fail_valid (fail_valid_z),
      .fail_vec   (fail_vec_z),
      .fail_y     (fail_y_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Netlist stand-ins: 0 = patched, 1 = unpatched NOR, 2 = patched with X at vector 5.
   function automatic logic [2:0] resp(input int m, input logic [2:0] a, input logic [2:0] b);
      logic [2:0] n;
      logic [5:0] ab;
      n  = ~(a | b);
      ab = {a, b};
      case (m)
         0:       return {n[2], 1'b0, n[0]};
         1:       return n;
         default: return (ab == 6'd5) ? 3'bxxx : {n[2], 1'b0, n[0]};
      endcase
   endfunction

   assign dut_y   = resp(mode, dut_a, dut_b);
   assign dut_y_z = resp(mode, dut_a_z, dut_b_z);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int m, input int settle);
      exp_t       e;
      logic [2:0] a, b, want, got;
      int         first;
      int         n_chk;
      e.err = 0; e.vec = '0; e.y = '0;
      first = -1;
      for (int v = 0; v < 64; v++) begin
         a    = 3'(v >> 3);
         b    = 3'(v);
         want = ~(a | b) & ~3'b010;
         got  = resp(m, a, b);
         if (got !== want) begin
            if (first < 0) begin
               first = v;
               e.vec = 6'(v);
               e.y   = got;
            end
            e.err++;
         end
      end
`ifdef ECO_CHK_STOP_ON_FAIL_EN
      n_chk = (first < 0) ? 64 : first + 1;
      e.err = (first < 0) ? 0 : 1;
`else
      n_chk = 64;
`endif
      e.pass = (e.err == 0);
      e.fv   = (first >= 0);
      e.lat  = 1 + n_chk * (2 + settle);
      return e;
   endfunction

   // Start at edge T, count negedges until done; negedge n lies just before edge T+n.
   task automatic run_sweep(input int inst, input int m, input bit hold, input string tag);
      exp_t e;
      int   n;
      bit   got;
      sb.push_back(model(m, (inst == 0) ? 1 : 0));
      mode = m;
      @(negedge clk);
      if (inst == 0) start = 1'b1; else start_z = 1'b1;
      @(posedge clk);
      n   = 0;
      got = 1'b0;
      while (n < 400 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1)
            chk({tag, "_restart"},
                (inst == 0) ? {62'd0, busy, done} : {62'd0, busy_z, done_z}, 64'd2);
         if ((inst == 0) ? done : done_z) got = 1'b1;
         if (!hold || got) begin
            start   = 1'b0;
            start_z = 1'b0;
         end
      end
      start   = 1'b0;
      start_z = 1'b0;
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      if (inst == 0) begin
         chk({tag, "_err"},   err_count,  e.err);
         chk({tag, "_pass"},  pass,       e.pass);
         chk({tag, "_fv"},    fail_valid, e.fv);
         chk({tag, "_fvec"},  fail_vec,   e.vec);
         chk({tag, "_fy"},    fail_y,     e.y);
      end else begin
         chk({tag, "_err"},   err_count_z,  e.err);
         chk({tag, "_pass"},  pass_z,       e.pass);
         chk({tag, "_fv"},    fail_valid_z, e.fv);
         chk({tag, "_fvec"},  fail_vec_z,   e.vec);
         chk({tag, "_fy"},    fail_y_z,     e.y);
      end
   endtask

   // Stimulus of the default instance must step by exactly one vector while busy.
   logic [5:0] last_v = '0;
   always @(negedge clk) begin
      logic [5:0] cur, nxt;
      cur = {dut_a, dut_b};
      nxt = last_v + 6'd1;
      if (!rst && busy && cur != last_v) chk("vec_step", cur, nxt);
      last_v = cur;
   end

   initial begin
      bit found;
      rst = 1'b1; start = 1'b0; start_z = 1'b0; mode = 0;
      repeat (2) @(negedge clk);
      chk("reset_state", {busy, done, pass, fail_valid, err_count, fail_vec, fail_y, dut_a, dut_b}, 64'd0);
      chk("reset_state_z", {busy_z, done_z, pass_z, fail_valid_z, err_count_z, fail_vec_z, fail_y_z,
                            dut_a_z, dut_b_z}, 64'd0);
      rst = 1'b0;

      run_sweep(0, 0, 1'b0, "patched");
      run_sweep(0, 1, 1'b1, "unpatched_hold");
      run_sweep(1, 0, 1'b0, "settle0_patched");
      run_sweep(1, 2, 1'b0, "settle0_xresp");

      // Reset in the middle of a sweep, then restart from scratch.
      mode = 1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if ({dut_a, dut_b} == 6'd10) found = 1'b1;
      end
      chk("reach_v10", found, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midsweep_reset", {busy, done, pass, fail_valid, err_count, fail_vec, fail_y, dut_a, dut_b}, 64'd0);
      run_sweep(0, 1, 1'b0, "after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eco_resp_checker.md
Name: eco_resp_checker

Overview:
- Response-side companion for the team's 3-bit bitwise ECO test netlists (module with inputs a, b and output y).
- Drives every (a,b) combination into the netlist under test and samples y after a programmable settle time.
- Compares y against a golden model: bitwise NOR of a and b, with ECO-patched bit positions expected at constant 0.
- Reports pass/fail, the mismatch count and the first failing vector. Instantiated in gate-level ECO benches alongside the netlist under test.

Parameters:
- WIDTH, 3, bit width of a, b and y.
- SETTLE_CYC, 1, idle cycles between driving a vector and sampling y (0 allowed).
- PATCH_MASK, 3'b010, WIDTH-bit mask; a 1 marks a bit whose expected value is forced to 0 by the ECO patch.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- dut_a  out  WIDTH  registered a stimulus.
- dut_b  out  WIDTH  registered b stimulus.
- dut_y  in  WIDTH  response from the netlist under test.
- busy  out  1  high from DRIVE through the last CHECK.
- done  out  1  level, high in DONE.
- pass  out  1  valid while done=1; 1 iff err_count==0.
- err_count  out  2*WIDTH+1  number of mismatching vectors.
- fail_valid  out  1  a first failure has been captured.
- fail_vec  out  2*WIDTH  {a,b} of the first failing vector.
- fail_y  out  WIDTH  dut_y observed at the first failure.

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-sweep:
  - state=IDLE, vector counter v=0, settle counter=0.
  - All outputs 0.
- Vector mapping: a=v[2W-1:W], b=v[W-1:0]. Expected value exp = ~(a|b) & ~PATCH_MASK.
- States:
  - IDLE: start=1 -> DRIVE, v=0, err_count, fail_* and fail_valid cleared.
  - DRIVE (1 cycle): load dut_a/dut_b from v; then SETTLE if SETTLE_CYC>0, else CHECK.
  - SETTLE: stays exactly SETTLE_CYC cycles, then CHECK.
  - CHECK (1 cycle): if dut_y != exp:
    - err_count increments.
    - If fail_valid=0, capture fail_vec=v and fail_y=dut_y, and set fail_valid=1.
  - CHECK exit: if v == 2^(2W)-1 -> DONE; else v increments and -> DRIVE.
  - DONE: done=1 and pass=(err_count==0), held until start=1, which restarts exactly as from IDLE.
- Cycle counts:
  - Per vector: 2+SETTLE_CYC cycles.
  - If start is sampled at edge T, done is first high at T+1+2^(2W)*(2+SETTLE_CYC). Defaults give T+193.
- dut_a/dut_b hold their last value in SETTLE, CHECK and DONE.
- start while busy is ignored; start and rst together: rst wins.
- err_count width covers all 2^(2W) vectors, so it never saturates or wraps.
- dut_y is sampled only in CHECK; an X on dut_y counts as a mismatch (case-inequality compare).

Optional Feature:
- Macro ECO_CHK_STOP_ON_FAIL_EN.
- Defined: a mismatch in CHECK goes directly to DONE after the capture, so err_count=1 and pass=0.
- Undefined: the full sweep always completes.

Decomposition:
- Package eco_chk_pkg:
  - state enum {IDLE, DRIVE, SETTLE, CHECK, DONE}.
  - Default WIDTH/PATCH_MASK constants.
  - Function gold_y(a,b,mask).
- One sub-module, eco_gold_model: combinational exp generator, reused by other ECO benches.

Test Plan:
- Defaults, DUT = patched model (y1=0, y0/y2 NOR): start at T -> done at T+193, pass=1, err_count=0, fail_valid=0.
- Defaults, DUT = unpatched NOR:
  - err_count=16 (vectors with a[1]=b[1]=0), pass=0.
  - fail_vec=6'b000000, fail_y=3'b111.
- ECO_CHK_STOP_ON_FAIL_EN defined, unpatched DUT: done at T+4, err_count=1, fail_vec=0.
- SETTLE_CYC=0 with a patched DUT: done at T+129, pass=1.
- rst pulsed during vector 10, then start re-issued: all outputs 0 after reset; the new sweep begins at v=0 with err_count cleared.
- start held high during busy: no restart (v progresses monotonically). start in DONE: new sweep, done drops the next cycle.
